// File: rtl/mixer_lo_sequencer.sv
// rtl/mixer_lo_sequencer.sv - LO phase-ramp sequencer driven by a stability-qualified software control word.
module mixer_lo_sequencer #(
  parameter int PHASE_W       = 16,
  parameter int STABLE_CYCLES = 2
) (
  input  logic               user_clk,
  input  logic               user_rst_n,
  input  logic [31:0]        reg_data,
  input  logic               sync_in,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic [PHASE_W-1:0] step_active,
  output logic               armed,
  output logic [15:0]        sync_count
);

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

  logic [31:0]        s1_q;
  logic [3:0]         cnt_q;
  logic [31:0]        word_q;
  logic               q_new_q;
  logic               rs_flip_q;

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [PHASE_W-1:0] pstep_q, pstep_d;
  logic               pvalid_q, pvalid_d;
  logic [15:0]        sync_q;
  logic               sync_inc;
  logic               phase_valid_q, armed_q;

  logic               q_en, q_arm;
  logic [PHASE_W-1:0] q_step;

  assign q_en   = word_q[31];
  assign q_arm  = word_q[29];
  assign q_step = word_q[PHASE_W-1:0];

  // A word is taken only on the edge its run of equal samples first hits STABLE_CYCLES.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      s1_q      <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      q_new_q   <= 1'b0;
      rs_flip_q <= 1'b0;
    end else begin
      s1_q      <= reg_data;
      q_new_q   <= 1'b0;
      rs_flip_q <= 1'b0;
      if (reg_data != s1_q) begin
        cnt_q <= '0;
      end else if (cnt_q != STABLE_C) begin
        cnt_q <= cnt_q + 4'd1;
      end
      if ((reg_data == s1_q) && (cnt_q == STABLE_C - 4'd1) && (reg_data != word_q)) begin
        word_q    <= reg_data;
        q_new_q   <= 1'b1;
        rs_flip_q <= reg_data[30] ^ word_q[30];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    step_d   = step_q;
    pstep_d  = pstep_q;
    pvalid_d = pvalid_q;
    sync_inc = 1'b0;
    case (state_q)
      IDLE: begin
        phase_d  = '0;
        pvalid_d = 1'b0;
        if (q_new_q && q_en) begin
          if (q_arm) begin
            state_d = ARMED;
            pstep_d = q_step;
          end else begin
            state_d = RUN;
            step_d  = q_step;
          end
        end
      end
      ARMED: begin
        phase_d = '0;
        if (q_new_q) begin
          if (!q_en) state_d = IDLE;
          else       pstep_d = q_step;
        end
      end
      RUN: begin
        phase_d = phase_q + step_q;
        if (q_new_q) begin
          if (!q_en) begin
            state_d  = IDLE;
            phase_d  = '0;
            pvalid_d = 1'b0;
          end else begin
            if (q_arm) begin
              pstep_d  = q_step;
              pvalid_d = 1'b1;
            end else begin
              step_d   = q_step;
              pvalid_d = 1'b0;
            end
            if (rs_flip_q) begin
              phase_d  = '0;
              sync_inc = 1'b1;
            end
          end
        end
        // sync_in sees the pending step as already updated by this cycle's word
        if ((state_d == RUN) && sync_in) begin
          if (pvalid_d) begin
            phase_d  = '0;
            step_d   = pstep_d;
            pvalid_d = 1'b0;
            sync_inc = 1'b1;
          end else if (q_arm) begin
            phase_d  = '0;
            sync_inc = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == ARMED) && sync_in) begin
      state_d  = RUN;
      step_d   = pstep_d;
      phase_d  = '0;
      sync_inc = 1'b1;
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      step_q        <= '0;
      pstep_q       <= '0;
      pvalid_q      <= 1'b0;
      sync_q        <= '0;
      phase_valid_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      step_q        <= step_d;
      pstep_q       <= pstep_d;
      pvalid_q      <= pvalid_d;
      if (sync_inc) sync_q <= sync_q + 16'd1;
      phase_valid_q <= (state_d == RUN);
      armed_q       <= (state_d == ARMED) || ((state_d == RUN) && pvalid_d);
    end
  end

  assign phase       = phase_q;
  assign phase_valid = phase_valid_q;
  assign step_active = step_q;
  assign armed       = armed_q;
  assign sync_count  = sync_q;

endmodule
